conv_window_controller: RTL and testbench
=========================================

Name: conv_window_controller

Overview:
- Sequences one KxK convolution pass over an IMG_W x IMG_W feature map for the CNN accelerator.
- Generates image-memory and weight-memory read addresses.
- Drives clr/ld of the accumulator Register and the result-write strobe.
- Sits between the layer-level top controller (start/done) and the MAC datapath (memories, multiplier, accumulator register).

Parameters:
IMG_W, 28, input map width = height in pixels
K, 3, kernel size (KxK window, stride 1, no padding)
IMG_AW, 10, image address width (must hold IMG_W*IMG_W-1)
W_AW, 4, weight address width (must hold K*K-1)
OUT_AW, 10, output address width (must hold (IMG_W-K+1)^2-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a pass when idle
busy  out  1  high from the first cycle after start is accepted until done
done  out  1  one-cycle pulse at end of pass
imgAddr  out  IMG_AW  image memory read address
wAddr  out  W_AW  weight memory read address
rdEn  out  1  read enable to both memories (sync read, 1-cycle latency)
accClr  out  1  clr to accumulator Register
accLd  out  1  ld to accumulator Register
outWr  out  1  write strobe for the result of the current window
outAddr  out  OUT_AW  result address = orow*(IMG_W-K+1)+ocol

Behaviour:
- Reset (async): state IDLE; every output and every counter is 0.
- Reset mid-pass: abort immediately, no done pulse.
- Outputs are registered; counters are orow, ocol (0..IMG_W-K) and kr, kc (0..K-1).
- States: IDLE -> CLEAR -> MAC -> DRAIN -> WRITE -> (CLEAR | DONE) -> IDLE.
- IDLE: start sampled high -> CLEAR.
  - start while not IDLE is ignored.
- CLEAR (1 cycle): accClr=1; kr=kc=0.
- MAC (K*K cycles): rdEn=1.
  - imgAddr=(orow+kr)*IMG_W+(ocol+kc); wAddr=kr*K+kc.
  - kc increments and wraps to 0 with kr++.
  - After kr=kc=K-1 -> DRAIN.
- accLd: a one-cycle-delayed copy of rdEn, so each ld is aligned with the memory data of the previous cycle's address. accLd is high for exactly K*K cycles per window: the last K*K-1 cycles of MAC plus DRAIN.
- DRAIN (1 cycle): rdEn=0; final accLd.
- WRITE (1 cycle): outWr=1; outAddr valid.
  - Then ocol++; on ocol wrap, ocol=0 and orow++.
  - Last window (orow=ocol=IMG_W-K) -> DONE, else -> CLEAR.
- DONE (1 cycle): done=1; busy=0 -> IDLE.
  - start in DONE is ignored.
- Cycles per window = K*K+3. Pass length = (IMG_W-K+1)^2*(K*K+3); done is asserted the cycle after the last WRITE.
- Address arithmetic is unsigned and computed at IMG_AW width. It never overflows given legal parameters.
- accClr, accLd and outWr are mutually exclusive in any cycle.

Optional Feature:
- Macro: CONV_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1: state and counters hold; rdEn=0; accClr=0; outWr=0.
  - accLd still fires once for an address issued in the cycle before stall rose, then stays 0.
  - On stall release, MAC resumes at the held (kr,kc), reissuing that address; no address is skipped or duplicated in ld.
  - Stall in IDLE/DONE has no effect.
- Undefined: no stall port; the sequence never pauses.

Test Plan:
- IMG_W=5,K=3: rst pulse, then start=1 for one cycle -> window 0 imgAddr sequence 0,1,2,5,6,7,10,11,12; wAddr 0..8; accClr once before it; accLd high 9 cycles; outWr with outAddr=0.
- Same config, full pass -> 9 outWr pulses, outAddr 0..8 in order; last window imgAddr 12,13,14,17,18,19,22,23,24; done pulses exactly 109 cycles after the start edge; busy low afterwards.
- start pulsed again during the pass at window 4 -> ignored: sequence unchanged, single done.
- Assert rst during MAC of window 3 -> all outputs 0 asynchronously; the next start restarts at window 0, imgAddr=0.
- Default IMG_W=28,K=3 -> 676 outWr pulses, final outAddr=675, done at cycle 8113; accClr/accLd/outWr never overlap.
- CONV_STALL_EN: stall high for 4 cycles when kr=1,kc=1 -> one trailing accLd, then a frozen imgAddr=6; total accLd count for the window is still 9; pass length grows by 4 cycles.

Source files
------------

// File: rtl/conv_window_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_window_controller
// Brief    : Sequences one KxK stride-1 convolution pass over an IMG_W x IMG_W
//            map: memory read addresses, accumulator clr/ld, result write.
//            Optional stall input when CONV_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_controller #(
    parameter int IMG_W  = 28,
    parameter int K      = 3,
    parameter int IMG_AW = 10,
    parameter int W_AW   = 4,
    parameter int OUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef CONV_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic [IMG_AW-1:0] imgAddr,
    output logic [W_AW-1:0]   wAddr,
    output logic              rdEn,
    output logic              accClr,
    output logic              accLd,
    output logic              outWr,
    output logic [OUT_AW-1:0] outAddr
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int KCW   = (K > 1) ? $clog2(K) : 1;

    localparam logic [OCW-1:0]    c_lastO = OCW'(OUT_W - 1);
    localparam logic [KCW-1:0]    c_lastK = KCW'(K - 1);
    localparam logic [IMG_AW-1:0] c_imgW  = IMG_AW'(IMG_W);
    localparam logic [W_AW-1:0]   c_k     = W_AW'(K);
    localparam logic [OUT_AW-1:0] c_outW  = OUT_AW'(OUT_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } stateT;

    stateT             r_state, w_nextState;
    logic [OCW-1:0]    r_orow, r_ocol, w_orow, w_ocol;
    logic [KCW-1:0]    r_kr, r_kc, w_kr, w_kc;
    logic              w_stall;
    logic [IMG_AW-1:0] w_imgAddr;
    logic [W_AW-1:0]   w_wAddr;
    logic [OUT_AW-1:0] w_outAddr;

    // Stall only freezes an active pass; IDLE and DONE ignore it.
`ifdef CONV_STALL_EN
    assign w_stall = stall && (r_state != IDLE) && (r_state != DONE);
`else
    assign w_stall = 1'b0;
`endif

    assign w_imgAddr = (IMG_AW'(r_orow) + IMG_AW'(r_kr)) * c_imgW
                     + IMG_AW'(r_ocol) + IMG_AW'(r_kc);
    assign w_wAddr   = W_AW'(r_kr) * c_k + W_AW'(r_kc);
    assign w_outAddr = OUT_AW'(r_orow) * c_outW + OUT_AW'(r_ocol);

    always_comb begin
        w_nextState = r_state;
        w_orow      = r_orow;
        w_ocol      = r_ocol;
        w_kr        = r_kr;
        w_kc        = r_kc;
        if (!w_stall) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_nextState = CLEAR;
                        w_orow      = '0;
                        w_ocol      = '0;
                    end
                end
                CLEAR: begin
                    w_kr        = '0;
                    w_kc        = '0;
                    w_nextState = MAC;
                end
                MAC: begin
                    if (r_kc == c_lastK) begin
                        w_kc = '0;
                        if (r_kr == c_lastK) begin
                            w_nextState = DRAIN;
                        end else begin
                            w_kr = r_kr + KCW'(1);
                        end
                    end else begin
                        w_kc = r_kc + KCW'(1);
                    end
                end
                DRAIN: w_nextState = WRITE;
                WRITE: begin
                    if (r_ocol == c_lastO) begin
                        w_ocol = '0;
                        if (r_orow == c_lastO) begin
                            w_nextState = DONE;
                        end else begin
                            w_orow      = r_orow + OCW'(1);
                            w_nextState = CLEAR;
                        end
                    end else begin
                        w_ocol      = r_ocol + OCW'(1);
                        w_nextState = CLEAR;
                    end
                end
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Outputs are registered from the current state, so the whole output
    // pattern trails the state register by one cycle; accLd trails rdEn by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            imgAddr <= '0;
            wAddr   <= '0;
            rdEn    <= 1'b0;
            accClr  <= 1'b0;
            accLd   <= 1'b0;
            outWr   <= 1'b0;
            outAddr <= '0;
        end else begin
            r_state <= w_nextState;
            r_orow  <= w_orow;
            r_ocol  <= w_ocol;
            r_kr    <= w_kr;
            r_kc    <= w_kc;
            busy    <= (r_state != IDLE) && (r_state != DONE);
            done    <= (r_state == DONE);
            accClr  <= (r_state == CLEAR) && !w_stall;
            rdEn    <= (r_state == MAC) && !w_stall;
            accLd   <= rdEn;
            outWr   <= (r_state == WRITE) && !w_stall;
            if (r_state == MAC) begin
                imgAddr <= w_imgAddr;
                wAddr   <= w_wAddr;
            end
            if (r_state == WRITE) begin
                outAddr <= w_outAddr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_controller
// Brief    : Scoreboard bench: 5x5/K=3 instance plus a default 28x28 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
`ifdef CONV_STALL_EN
    logic       stall;
`endif
    logic       busy, done, rdEn, accClr, accLd, outWr;
    logic [4:0] imgAddr;
    logic [3:0] wAddr;
    logic [3:0] outAddr;
    logic       busy2, done2, rdEn2, accClr2, accLd2, outWr2;
    logic [9:0] imgAddr2;
    logic [3:0] wAddr2;
    logic [9:0] outAddr2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ldCnt = 0;
    int clrCnt = 0;
    int wr2Cnt = 0;
    int lastAddr2 = 0;

    typedef struct packed {
        logic [4:0] img;
        logic [3:0] w;
    } rdT;

    rdT         expRd[$];
    logic [3:0] expWr[$];

    conv_window_controller #(
        .IMG_W(5), .K(3), .IMG_AW(5), .W_AW(4), .OUT_AW(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CONV_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .imgAddr(imgAddr), .wAddr(wAddr),
        .rdEn(rdEn), .accClr(accClr), .accLd(accLd), .outWr(outWr),
        .outAddr(outAddr)
    );

    conv_window_controller dut2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef CONV_STALL_EN
        .stall(1'b0),
`endif
        .busy(busy2), .done(done2), .imgAddr(imgAddr2), .wAddr(wAddr2),
        .rdEn(rdEn2), .accClr(accClr2), .accLd(accLd2), .outWr(outWr2),
        .outAddr(outAddr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_busy"},    32'(busy),    0);
        chk({tag, "_done"},    32'(done),    0);
        chk({tag, "_imgAddr"}, 32'(imgAddr), 0);
        chk({tag, "_wAddr"},   32'(wAddr),   0);
        chk({tag, "_rdEn"},    32'(rdEn),    0);
        chk({tag, "_accClr"},  32'(accClr),  0);
        chk({tag, "_accLd"},   32'(accLd),   0);
        chk({tag, "_outWr"},   32'(outWr),   0);
        chk({tag, "_outAddr"}, 32'(outAddr), 0);
    endtask

    // Expected reads/writes for one full 5x5, K=3 pass (windows 0 and 8 hand-listed).
    task automatic pushPass();
        rdT e;
        int win0[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int win8[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        for (int w = 0; w < 9; w++) begin
            for (int k = 0; k < 9; k++) begin
                if (w == 0)      e.img = 5'(win0[k]);
                else if (w == 8) e.img = 5'(win8[k]);
                else             e.img = 5'(((w / 3) + (k / 3)) * 5 + (w % 3) + (k % 3));
                e.w = 4'(k);
                expRd.push_back(e);
            end
            expWr.push_back(4'(w));
        end
    endtask

    always @(negedge clk) begin : monitor
        rdT         e;
        logic [3:0] ew;
        int         n;
        if (rst) begin
            ldCnt  = 0;
            clrCnt = 0;
        end else begin
            if (accClr) clrCnt++;
            if (accLd)  ldCnt++;
            n = int'(accClr) + int'(accLd) + int'(outWr);
            if (n > 0) chk("excl", 32'(n), 1);
            if (rdEn) begin
                if (expRd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_extra actual img=%0d required none", imgAddr);
                end else begin
                    e = expRd.pop_front();
                    chk("rd_img", 32'(imgAddr), 32'(e.img));
                    chk("rd_w",   32'(wAddr),   32'(e.w));
                end
            end
            if (outWr) begin
                if (expWr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_extra actual outAddr=%0d required none", outAddr);
                end else begin
                    ew = expWr.pop_front();
                    chk("wr_addr", 32'(outAddr), 32'(ew));
                end
                chk("ld_count",  32'(ldCnt),  9);
                chk("clr_count", 32'(clrCnt), 1);
                ldCnt  = 0;
                clrCnt = 0;
            end
            n = int'(accClr2) + int'(accLd2) + int'(outWr2);
            if (n > 0) chk("excl2", 32'(n), 1);
            if (outWr2) begin
                wr2Cnt++;
                lastAddr2 = int'(outAddr2);
            end
        end
    end

    task automatic runPass(input bit midStart, input bit doStall);
        int t0;
        int expLen;
        int stallLeft;
        bit got;
        bit stalled;
        expLen    = doStall ? 113 : 109;
        got       = 1'b0;
        stalled   = 1'b0;
        stallLeft = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; t0 = cyc;
        for (int i = 1; i <= expLen + 20 && !got; i++) begin
            @(negedge clk);
            start = midStart && ((cyc == t0 + 51) || (cyc == t0 + 108));
`ifdef CONV_STALL_EN
            if (stallLeft > 0) begin
                chk("stall_img", 32'(imgAddr), 6);
                chk("stall_rdEn", 32'(rdEn), 0);
                chk("stall_accLd", 32'(accLd), (stallLeft == 4) ? 1 : 0);
                stallLeft--;
                if (stallLeft == 0) stall = 1'b0;
            end else if (doStall && !stalled && rdEn && imgAddr == 5'd5) begin
                stalled   = 1'b1;
                stall     = 1'b1;
                stallLeft = 4;
            end
`endif
            if (done) begin
                got = 1'b1;
                chk("done_latency", 32'(cyc - t0), 32'(expLen));
                chk("busy_at_done", 32'(busy), 0);
            end else if (i == 20) begin
                chk("busy_mid", 32'(busy), 1);
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 32'(got), 1);
        repeat (15) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done), 0);
        end
        chk("busy_after", 32'(busy), 0);
        chk("rd_queue_empty", 32'(expRd.size()), 0);
        chk("wr_queue_empty", 32'(expWr.size()), 0);
    endtask

    initial begin : stimulus
        int  t0;
        bit  got;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
`ifdef CONV_STALL_EN
        stall  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chkAllZero("reset");
        rst = 1'b0;

        pushPass();
        runPass(1'b0, 1'b0);

        pushPass();
        runPass(1'b1, 1'b0);

        // Abort during MAC of window 3, then restart from window 0.
        pushPass();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; t0 = cyc;
        while (cyc < t0 + 41) @(negedge clk);
        chk("pre_rst_rdEn", 32'(rdEn), 1);
        #3 rst = 1'b1;
        #1 chkAllZero("midrst");
        expRd.delete();
        expWr.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pushPass();
        runPass(1'b0, 1'b0);

`ifdef CONV_STALL_EN
        pushPass();
        runPass(1'b0, 1'b1);
`endif

        wr2Cnt = 0;
        got    = 1'b0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0; t0 = cyc;
        for (int i = 0; i < 8200 && !got; i++) begin
            @(negedge clk);
            if (done2) begin
                got = 1'b1;
                chk("d2_latency", 32'(cyc - t0), 8113);
            end
        end
        if (!got) chk("d2_timeout", 32'(got), 1);
        chk("d2_wr_count", 32'(wr2Cnt), 676);
        chk("d2_last_addr", 32'(lastAddr2), 675);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
